// File: rtl/iram_port_arb_if.sv
// iram_port_arb_if: single-beat request/grant port between one RAM master and the arbiter.
interface iram_port_arb_if #(
    parameter int AW = 15,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    wem;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, wem, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, wem, output gnt, rvalid, rdata);
endinterface

// File: rtl/iram_port_arb.sv
// iram_port_arb: round-robin arbiter with bounded locking between the load/store unit (m0)
// and the loader/debug path (m1) onto the data-side RAM port.
module iram_port_arb #(
    parameter int AW       = 15,
    parameter int DW       = 32,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    iram_port_arb_if.slave m0,
    iram_port_arb_if.slave m1,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic [3:0]    ram_wem,
    input  logic [DW-1:0] ram_rdata,
    output logic          owner
);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t        state, state_nx;
    logic          last, last_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic          lock_own, own_req, oth_req, idle_win, win, any, lock_w;

    always_comb begin
        lock_own = (state == LOCK1);
        own_req  = lock_own ? m1.req : m0.req;
        oth_req  = lock_own ? m0.req : m1.req;
        idle_win = m0.req ? (m1.req & ~last) : 1'b1;
        // A locked owner yields exactly once its hold budget is spent and the other side waits.
        win      = (state != IDLE && own_req) ? (lock_own ^ (hold_cnt == HMAX && oth_req)) : idle_win;
        any      = rst_n & (m0.req | m1.req);
        lock_w   = win ? m1.lock : m0.lock;
        state_nx = IDLE;
        last_nx  = last;
        hold_nx  = '0;
        if (any) begin
            state_nx = lock_w ? (win ? LOCK1 : LOCK0) : IDLE;
            last_nx  = win;
            hold_nx  = (win != last) ? HW'(1) : (hold_cnt == HMAX) ? HMAX : hold_cnt + 1'b1;
        end
    end

    assign m0.gnt    = any & ~win;
    assign m1.gnt    = any & win;
    assign ram_en    = any;
    assign ram_we    = any & (win ? m1.we : m0.we);
    assign ram_addr  = any ? (win ? m1.addr : m0.addr) : '0;
    assign ram_wdata = any ? (win ? m1.wdata : m0.wdata) : '0;
    assign ram_wem   = ram_we ? (win ? m1.wem : m0.wem) : 4'b0;
    assign m0.rdata  = ram_rdata;
    assign m1.rdata  = ram_rdata;
    assign owner     = last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            hold_cnt  <= '0;
            m0.rvalid <= 1'b0;
            m1.rvalid <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            hold_cnt  <= hold_nx;
            m0.rvalid <= m0.gnt & ~m0.we;
            m1.rvalid <= m1.gnt & ~m1.we;
        end
    end
endmodule

// File: tb/tb_iram_port_arb.sv
// tb_iram_port_arb: directed scenarios for iram_port_arb with hand-computed expectations.
module tb_iram_port_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_en, ram_we, owner;
    logic [14:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_wem;
    int          checks = 0;
    int          failures = 0;

    iram_port_arb_if #(.AW(15), .DW(32)) m0_bus ();
    iram_port_arb_if #(.AW(15), .DW(32)) m1_bus ();

    iram_port_arb #(.AW(15), .DW(32), .HOLD_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0_bus), .m1(m1_bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wem(ram_wem), .ram_rdata(ram_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n = 1'b0;
        m0_bus.req = 0; m1_bus.req = 0; m0_bus.lock = 0; m1_bus.lock = 0;
        m0_bus.we = 0; m1_bus.we = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m0_bus.req = 1; m1_bus.req = 1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m0_bus.gnt !== 1'b0) begin failures++; $display("FAIL reset_m0_gnt got=%b exp=0", m0_bus.gnt); end
        checks++; if (m1_bus.gnt !== 1'b0) begin failures++; $display("FAIL reset_m1_gnt got=%b exp=0", m1_bus.gnt); end
        checks++; if (ram_en !== 1'b0) begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL reset_owner got=%b exp=1", owner); end
        checks++; if (m0_bus.rvalid !== 1'b0 || m1_bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b%b exp=00", m0_bus.rvalid, m1_bus.rvalid); end
        checks++; if (dut.hold_cnt !== 3'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", dut.hold_cnt); end
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state); end
        m0_bus.req = 0; m1_bus.req = 0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        m0_bus.req = 1; m0_bus.we = 0; m0_bus.addr = 15'h010; m0_bus.wem = 4'hF; m0_bus.wdata = 32'hCAFE0001;
        @(negedge clk);
        checks++; if (m0_bus.gnt !== 1'b1 || m1_bus.gnt !== 1'b0) begin failures++; $display("FAIL rd_gnt got=%b%b exp=10", m0_bus.gnt, m1_bus.gnt); end
        checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin failures++; $display("FAIL rd_en_we got=%b%b exp=10", ram_en, ram_we); end
        checks++; if (ram_addr !== 15'h010) begin failures++; $display("FAIL rd_addr got=%h exp=010", ram_addr); end
        checks++; if (ram_wem !== 4'b0) begin failures++; $display("FAIL rd_wem got=%b exp=0000", ram_wem); end
        @(posedge clk); #1;
        m0_bus.req = 0; ram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        checks++; if (m0_bus.rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%b exp=1", m0_bus.rvalid); end
        checks++; if (m0_bus.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", m0_bus.rdata); end
        checks++; if (m1_bus.rvalid !== 1'b0) begin failures++; $display("FAIL rd_m1_rvalid got=%b exp=0", m1_bus.rvalid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m0_bus.rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_drop got=%b exp=0", m0_bus.rvalid); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        logic e;
        do_reset;
        m0_bus.req = 1; m1_bus.req = 1;
        for (int i = 0; i < 6; i++) begin
            e = i[0];
            @(negedge clk);
            checks++; if (m0_bus.gnt !== ~e || m1_bus.gnt !== e) begin failures++; $display("FAIL rr_gnt%0d got=%b%b exp=%b%b", i, m0_bus.gnt, m1_bus.gnt, ~e, e); end
            checks++; if (owner !== ~e) begin failures++; $display("FAIL rr_owner%0d got=%b exp=%b", i, owner, ~e); end
            checks++; if (m0_bus.rvalid !== e || m1_bus.rvalid !== (~e & (i > 0))) begin failures++; $display("FAIL rr_rvalid%0d got=%b%b exp=%b%b", i, m0_bus.rvalid, m1_bus.rvalid, e, ~e & (i > 0)); end
            @(posedge clk); #1;
        end
        m0_bus.req = 0; m1_bus.req = 0;
    endtask

    task automatic test_lock_hold;
        logic e;
        do_reset;
        m0_bus.addr = 15'h111; m1_bus.addr = 15'h222;
        m1_bus.req = 1; m1_bus.lock = 1;
        for (int c = 0; c < 8; c++) begin
            m0_bus.req = (c >= 1 && c <= 4);
            e = (c != 4);
            @(negedge clk);
            checks++; if (m1_bus.gnt !== e || m0_bus.gnt !== ~e) begin failures++; $display("FAIL lock_gnt%0d got=%b%b exp=%b%b", c, m0_bus.gnt, m1_bus.gnt, ~e, e); end
            checks++; if (ram_addr !== (e ? 15'h222 : 15'h111)) begin failures++; $display("FAIL lock_addr%0d got=%h exp=%h", c, ram_addr, e ? 15'h222 : 15'h111); end
            @(posedge clk); #1;
        end
        m0_bus.req = 0; m1_bus.req = 0; m1_bus.lock = 0;
    endtask

    task automatic test_lock_solo;
        do_reset;
        m1_bus.req = 1; m1_bus.lock = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++; if (m1_bus.gnt !== 1'b1 || m0_bus.gnt !== 1'b0) begin failures++; $display("FAIL solo_gnt%0d got=%b%b exp=01", c, m0_bus.gnt, m1_bus.gnt); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (dut.hold_cnt !== 3'd4) begin failures++; $display("FAIL solo_hold got=%0d exp=4", dut.hold_cnt); end
        checks++; if (dut.state !== 2'd2) begin failures++; $display("FAIL solo_state got=%0d exp=2", dut.state); end
        @(posedge clk); #1;
        m1_bus.req = 0; m1_bus.lock = 0;
    endtask

    task automatic test_reset_drop;
        do_reset;
        m0_bus.req = 1; m0_bus.we = 0; m0_bus.addr = 15'h005;
        @(negedge clk);
        checks++; if (m0_bus.gnt !== 1'b1) begin failures++; $display("FAIL drop_gnt got=%b exp=1", m0_bus.gnt); end
        rst_n = 1'b0; m0_bus.req = 0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m0_bus.rvalid !== 1'b0 || m1_bus.rvalid !== 1'b0) begin failures++; $display("FAIL drop_rvalid got=%b%b exp=00", m0_bus.rvalid, m1_bus.rvalid); end
        @(posedge clk); #1;
        rst_n = 1'b1; m0_bus.req = 1; m1_bus.req = 1;
        @(negedge clk);
        checks++; if (m0_bus.gnt !== 1'b1 || m1_bus.gnt !== 1'b0) begin failures++; $display("FAIL drop_tie got=%b%b exp=10", m0_bus.gnt, m1_bus.gnt); end
        @(posedge clk); #1;
        m0_bus.req = 0; m1_bus.req = 0;
    endtask

    task automatic test_write;
        do_reset;
        m0_bus.req = 1; m0_bus.we = 1; m0_bus.addr = 15'h7FFF; m0_bus.wdata = 32'h12345678; m0_bus.wem = 4'b0011;
        @(negedge clk);
        checks++; if (m0_bus.gnt !== 1'b1 || ram_en !== 1'b1) begin failures++; $display("FAIL wr_gnt_en got=%b%b exp=11", m0_bus.gnt, ram_en); end
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL wr_we got=%b exp=1", ram_we); end
        checks++; if (ram_wem !== 4'b0011) begin failures++; $display("FAIL wr_wem got=%b exp=0011", ram_wem); end
        checks++; if (ram_wdata !== 32'h12345678) begin failures++; $display("FAIL wr_wdata got=%h exp=12345678", ram_wdata); end
        checks++; if (ram_addr !== 15'h7FFF) begin failures++; $display("FAIL wr_addr got=%h exp=7fff", ram_addr); end
        @(posedge clk); #1;
        m0_bus.req = 0;
        @(negedge clk);
        checks++; if (m0_bus.rvalid !== 1'b0 || m1_bus.rvalid !== 1'b0) begin failures++; $display("FAIL wr_rvalid got=%b%b exp=00", m0_bus.rvalid, m1_bus.rvalid); end
        checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 15'h0 || ram_wem !== 4'b0 || ram_wdata !== 32'h0) begin failures++; $display("FAIL idle_ram got=%b%b %h %b %h exp=00 0000 0000 00000000", ram_en, ram_we, ram_addr, ram_wem, ram_wdata); end
        @(posedge clk); #1;
        m0_bus.we = 0;
    endtask

    initial begin
        m0_bus.req = 0; m0_bus.we = 0; m0_bus.lock = 0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wem = '0;
        m1_bus.req = 0; m1_bus.we = 0; m1_bus.lock = 0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wem = '0;
        ram_rdata = '0;
        test_reset;
        test_single_read;
        test_round_robin;
        test_lock_hold;
        test_lock_solo;
        test_reset_drop;
        test_write;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
